// File: rtl/midi_voice_alloc_pkg.sv
// ---------------------------------------------------------------------------
// midi_voice_alloc_pkg
//   Shared definitions for the polyphonic voice allocator: default sizes,
//   MIDI key width, FSM state encoding and the registered decision opcode.
//   Imported by midi_voice_alloc and voice_select.
// ---------------------------------------------------------------------------
package midi_voice_alloc_pkg;

    localparam int NUM_VOICES_DEF = 4;
    localparam int AGE_W_DEF      = 8;
    localparam int MIDI_KEY_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // What COMMIT must do with the captured event.
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,   // dropped note-on (all voices busy, stealing disabled)
        OP_ON   = 2'd1,   // load target voice
        OP_OFF  = 2'd2    // close gate of every voice holding the key
    } op_t;

endpackage

// File: rtl/voice_select.sv
// ---------------------------------------------------------------------------
// voice_select
//   Purely combinational voice search for the allocator.
//   Ports:
//     gate       in  NV          voice sounding flags
//     keys       in  8*NV        key of voice i at [8i+7:8i]
//     ages       in  AGE_W*NV    age of voice i
//     ev_key     in  8           key being looked up
//     match_idx  out IDX_W       lowest gated voice holding ev_key
//     match_vld  out 1           such a voice exists
//     free_idx   out IDX_W       lowest voice with gate=0
//     free_vld   out 1           such a voice exists
//     oldest_idx out IDX_W       gated voice with the largest age, ties -> lowest
// ---------------------------------------------------------------------------
module voice_select
    import midi_voice_alloc_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int AGE_W      = AGE_W_DEF,
    parameter int IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic [NUM_VOICES-1:0]            gate,
    input  logic [NUM_VOICES*MIDI_KEY_W-1:0] keys,
    input  logic [NUM_VOICES*AGE_W-1:0]      ages,
    input  logic [MIDI_KEY_W-1:0]            ev_key,
    output logic [IDX_W-1:0]                 match_idx,
    output logic                             match_vld,
    output logic [IDX_W-1:0]                 free_idx,
    output logic                             free_vld,
    output logic [IDX_W-1:0]                 oldest_idx
);

    logic [MIDI_KEY_W-1:0] key_arr [NUM_VOICES];
    logic [AGE_W-1:0]      age_arr [NUM_VOICES];

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_unpack
        assign key_arr[gi] = keys[gi*MIDI_KEY_W +: MIDI_KEY_W];
        assign age_arr[gi] = ages[gi*AGE_W +: AGE_W];
    end

    // Match / free: scan downwards so the lowest index is the last writer.
    always_comb begin
        match_idx = '0;
        match_vld = 1'b0;
        free_idx  = '0;
        free_vld  = 1'b0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (gate[i] && key_arr[i] == ev_key) begin
                match_idx = IDX_W'(i);
                match_vld = 1'b1;
            end
            if (!gate[i]) begin
                free_idx = IDX_W'(i);
                free_vld = 1'b1;
            end
        end
    end

    // Oldest: scan upwards with strict '>' so ties stay on the lowest index.
    always_comb begin
        logic             found;
        logic [AGE_W-1:0] best_age;
        found      = 1'b0;
        best_age   = '0;
        oldest_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (gate[i] && (!found || age_arr[i] > best_age)) begin
                found      = 1'b1;
                best_age   = age_arr[i];
                oldest_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/midi_voice_alloc.sv
// ---------------------------------------------------------------------------
// midi_voice_alloc
//   Polyphonic voice allocator between the MIDI note FIFO and NUM_VOICES
//   synth voices. Pops at most one note event per sample tick.
//   Note-on: retrigger matching key, else lowest free voice, else steal the
//   oldest gated voice (only when VOICE_STEAL_EN is defined; otherwise the
//   event is dropped but still popped). Note-off (velocity 0) closes every
//   gated voice holding the key.
//   Build option: `define VOICE_STEAL_EN to enable voice stealing.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     sample_tick     1-cycle strobe per audio sample
//     fifo_empty      FIFO empty; key/velocity valid while low (FWFT)
//     key, velocity   head-of-FIFO event, velocity 0 = note-off
//     fifo_rd         1-cycle pop strobe (COMMIT)
//     voice_newnote   per-voice 1-cycle reload pulse
//     voice_gate      per-voice sounding flag
//     voice_key       key of voice i at [8i+7:8i]
//     voice_vel       velocity[6:0] of voice i at [7i+6:7i]
//   Timing: tick at T -> EVAL at T+1 -> COMMIT at T+2 (fifo_rd, newnote);
//   voice registers take the new values at the clock edge closing COMMIT.
// ---------------------------------------------------------------------------
module midi_voice_alloc
    import midi_voice_alloc_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int AGE_W      = AGE_W_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sample_tick,
    input  logic                             fifo_empty,
    input  logic [MIDI_KEY_W-1:0]            key,
    input  logic [7:0]                       velocity,
    output logic                             fifo_rd,
    output logic [NUM_VOICES-1:0]            voice_newnote,
    output logic [NUM_VOICES-1:0]            voice_gate,
    output logic [NUM_VOICES*MIDI_KEY_W-1:0] voice_key,
    output logic [NUM_VOICES*7-1:0]          voice_vel
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

`ifdef VOICE_STEAL_EN
    localparam bit STEAL_EN = 1'b1;
`else
    localparam bit STEAL_EN = 1'b0;
`endif

    state_t                  state_reg, state_next;
    logic [MIDI_KEY_W-1:0]   ev_key_reg;
    logic [7:0]              ev_vel_reg;
    op_t                     op_reg, op_next;
    logic [IDX_W-1:0]        tgt_reg, tgt_next;
    logic [NUM_VOICES-1:0]   off_mask_reg;
    logic [NUM_VOICES-1:0]   key_hit;
    logic [NUM_VOICES*AGE_W-1:0] age_vec;

    logic [IDX_W-1:0] match_idx, free_idx, oldest_idx;
    logic             match_vld, free_vld;

    voice_select #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W),
        .IDX_W      (IDX_W)
    ) u_select (
        .gate       (voice_gate),
        .keys       (voice_key),
        .ages       (age_vec),
        .ev_key     (ev_key_reg),
        .match_idx  (match_idx),
        .match_vld  (match_vld),
        .free_idx   (free_idx),
        .free_vld   (free_vld),
        .oldest_idx (oldest_idx)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:   if (sample_tick && !fifo_empty) state_next = ST_EVAL;
            ST_EVAL:   state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Target decision, evaluated in EVAL from the captured event.
    always_comb begin
        op_next  = OP_NONE;
        tgt_next = match_idx;
        if (ev_vel_reg == 8'd0) begin
            op_next = OP_OFF;
        end else if (match_vld) begin
            op_next  = OP_ON;
            tgt_next = match_idx;
        end else if (free_vld) begin
            op_next  = OP_ON;
            tgt_next = free_idx;
        end else if (STEAL_EN) begin
            op_next  = OP_ON;
            tgt_next = oldest_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_key_reg   <= '0;
            ev_vel_reg   <= '0;
            op_reg       <= OP_NONE;
            tgt_reg      <= '0;
            off_mask_reg <= '0;
        end else begin
            if (state_reg == ST_IDLE && sample_tick && !fifo_empty) begin
                ev_key_reg <= key;
                ev_vel_reg <= velocity;
            end
            if (state_reg == ST_EVAL) begin
                op_reg       <= op_next;
                tgt_reg      <= tgt_next;
                off_mask_reg <= key_hit;
            end
        end
    end

    logic commit_on, commit_off;
    assign fifo_rd    = (state_reg == ST_COMMIT);
    assign commit_on  = fifo_rd && (op_reg == OP_ON);
    assign commit_off = fifo_rd && (op_reg == OP_OFF);

    // ---------------- per-voice state ----------------
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        logic                  gate_reg;
        logic [MIDI_KEY_W-1:0] key_reg;
        logic [6:0]            vel_reg;
        logic [AGE_W-1:0]      age_reg;
        logic                  is_tgt;

        assign is_tgt = (tgt_reg == IDX_W'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                gate_reg <= 1'b0;
                key_reg  <= '0;
                vel_reg  <= '0;
                age_reg  <= '0;
            end else begin
                if (commit_on && is_tgt) begin
                    gate_reg <= 1'b1;
                    key_reg  <= ev_key_reg;
                    vel_reg  <= ev_vel_reg[6:0];
                    age_reg  <= '0;   // wins over a coincident tick
                end else begin
                    if (commit_off && off_mask_reg[gi]) gate_reg <= 1'b0;
                    if (sample_tick && gate_reg && age_reg != AGE_MAX)
                        age_reg <= age_reg + 1'b1;
                end
            end
        end

        assign key_hit[gi]                            = gate_reg && (key_reg == ev_key_reg);
        assign voice_gate[gi]                         = gate_reg;
        assign voice_newnote[gi]                      = commit_on && is_tgt;
        assign voice_key[gi*MIDI_KEY_W +: MIDI_KEY_W] = key_reg;
        assign voice_vel[gi*7 +: 7]                   = vel_reg;
        assign age_vec[gi*AGE_W +: AGE_W]             = age_reg;
    end

endmodule
